// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: latches button event pulses into CPU-visible pending/count/status registers with a masked IRQ.
// Optional IRQ re-arm holdoff enabled by defining BTN_EVENT_IRQ_HOLDOFF_EN.
module btn_event_ctrl #(
  parameter int CNT_W = 16,
  parameter int HOLDOFF_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        SYNC_BTNU_INT,
  input  logic        SYNC_BTNL_INT,
  input  logic        SYNC_BTNR_INT,
  input  logic        SYNC_BTND_INT,
  input  logic        SYNC_BTNC_INT,
  input  logic [3:0]  ADDR,
  input  logic        WEN,
  input  logic [31:0] WDATA,
  input  logic        REN,
  output logic [31:0] RDATA,
  output logic        RVALID,
  output logic        IRQ
);
  logic [4:0] ev, pend, mask, w1c, pend_nx, mask_nx;
  logic [1:0] a;
  logic ovf, ovf_nx, last_valid, irq_raw, irq_nx;
  logic [2:0] last, last_nx, pc;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0] rd;
  assign ev = {SYNC_BTNC_INT, SYNC_BTND_INT, SYNC_BTNR_INT, SYNC_BTNL_INT, SYNC_BTNU_INT};
  assign a = ADDR[3:2];
  always_comb begin
    w1c = (WEN && a == 2'd0) ? WDATA[4:0] : 5'd0;
    pend_nx = (pend & ~w1c) | ev;
    mask_nx = (WEN && a == 2'd1) ? WDATA[4:0] : mask;
    ovf_nx = (|(ev & pend)) | (ovf & !(WEN && a == 2'd2 && WDATA[8]));
    pc = 3'(ev[0]) + 3'(ev[1]) + 3'(ev[2]) + 3'(ev[3]) + 3'(ev[4]);
    cnt_nx = ((WEN && a == 2'd3) ? '0 : cnt) + CNT_W'(pc);
    last_nx = ev[0] ? 3'd0 : ev[1] ? 3'd1 : ev[2] ? 3'd2 : ev[3] ? 3'd3 : 3'd4;
    rd = a == 2'd0 ? {27'd0, pend} :
         a == 2'd1 ? {27'd0, mask} :
         a == 2'd2 ? {23'd0, ovf, 4'd0, last_valid, last} : 32'(cnt);
    irq_raw = |(pend_nx & mask_nx);
  end
`ifdef BTN_EVENT_IRQ_HOLDOFF_EN
  localparam int HW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  logic [HW-1:0] hold;
  assign irq_nx = (hold == '0) && irq_raw;
  // every IRQ fall re-arms the holdoff; IRQ stays low until it drains
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) hold <= '0;
    else hold <= (IRQ && !irq_nx) ? HW'(HOLDOFF_CYCLES - 1) : hold - HW'(hold != '0);
`else
  assign irq_nx = irq_raw;
`endif
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend <= '0;
      mask <= '0;
      ovf <= 1'b0;
      last <= '0;
      last_valid <= 1'b0;
      cnt <= '0;
      RDATA <= '0;
      RVALID <= 1'b0;
      IRQ <= 1'b0;
    end else begin
      pend <= pend_nx;
      mask <= mask_nx;
      ovf <= ovf_nx;
      last <= (ev != 5'd0) ? last_nx : last;
      last_valid <= last_valid | (ev != 5'd0);
      cnt <= cnt_nx;
      RDATA <= REN ? rd : RDATA;
      RVALID <= REN;
      IRQ <= irq_nx;
    end
  end
endmodule
